// File: rtl/rgb_pkg.sv
// Shared timing constants for the WS2812 front end and the downstream assembler.
package rgb_pkg;

    localparam int COUNTER_MAX       = 5000;
    localparam int STREAM_RESET_CLKS = 4800;
    localparam int SAMPLE_TIME_CLKS  = 57;

endpackage

// File: rtl/rgb_sinp_sync.sv
// Input synchronizer and rising-edge detector for the raw single-wire stream.
// Optional 1-cycle glitch filter enabled by defining RGB_SINP_GLITCH_FILTER_EN.
module rgb_sinp_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic sig_s,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= sig;
            sync_p1 <= sync_p0;
        end
    end

`ifdef RGB_SINP_GLITCH_FILTER_EN
    logic filt_p2;

    // Follow the synchronizer only once two successive outputs agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_p2 <= 1'b0;
        end else if (sync_p0 == sync_p1) begin
            filt_p2 <= sync_p1;
        end
    end

    assign sig_s = filt_p2;
`else
    assign sig_s = sync_p1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;

endmodule

// File: rtl/rgb_sinp.sv
// WS2812-style NRZ decoder: rising edge starts a bit, level at a fixed delay is the bit.
// Build option: RGB_SINP_GLITCH_FILTER_EN adds a 1-cycle glitch filter (+1 cycle latency).
module rgb_sinp #(
    parameter int COUNTER_MAX       = rgb_pkg::COUNTER_MAX,
    parameter int STREAM_RESET_CLKS = rgb_pkg::STREAM_RESET_CLKS,
    parameter int SAMPLE_TIME_CLKS  = rgb_pkg::SAMPLE_TIME_CLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic out,
    output logic strobe,
    output logic stream_reset
);

    localparam int CNT_W = $clog2(COUNTER_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(COUNTER_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_TIME_CLKS);
    localparam logic [CNT_W-1:0] CNT_IDLE   = CNT_W'(STREAM_RESET_CLKS);

    logic             sig_s;
    logic             rise;
    logic [CNT_W-1:0] cnt;

    // Saturating increment: the counter parks at CNT_MAX so idle never re-triggers.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v < CNT_MAX) ? v + CNT_ONE : v;
    endfunction

    rgb_sinp_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig   (sig),
        .sig_s (sig_s),
        .rise  (rise)
    );

    // Reset parks cnt at saturation so no stray strobe/stream_reset follows release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= CNT_MAX;
            out          <= 1'b0;
            strobe       <= 1'b0;
            stream_reset <= 1'b0;
        end else begin
            cnt          <= rise ? CNT_ONE : sat_inc(cnt);
            strobe       <= 1'b0;
            stream_reset <= !rise && (cnt == CNT_IDLE);
            if (!rise && (cnt == CNT_SAMPLE)) begin
                out    <= sig_s;
                strobe <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_sinp.sv
// Scoreboard bench for rgb_sinp: expected strobe/stream_reset events queued at stimulus time.
module tb_rgb_sinp;

    localparam int SAMPLE   = 57;
    localparam int IDLE     = 4800;
    // Drive at negedge with posedge count N: edge 0 is posedge N+1.
    localparam int STB_LAT  = 1 + SAMPLE + 2;
    localparam int IDLE_LAT = 1 + IDLE + 2;

    typedef struct {
        bit kind;   // 0 = strobe, 1 = stream_reset
        bit val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sig = 1'b0;
    logic out;
    logic strobe;
    logic stream_reset;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_start = 0;
    ev_t  exp_q[$];

    rgb_sinp dut (
        .clk          (clk),
        .rst          (rst),
        .sig          (sig),
        .out          (out),
        .strobe       (strobe),
        .stream_reset (stream_reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        ev_t e;
        bit  hit;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                hit = (k == 0) ? strobe : stream_reset;
                if (hit) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_pulse kind=%0d cycle=%0d out=%b, required no pulse", k, cyc, out);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind !== k[0] || e.cyc !== cyc || (k == 0 && out !== e.val)) begin
                            miscompares++;
                            $display("FAIL event kind=%0d cycle=%0d out=%b, required kind=%0d cycle=%0d out=%b",
                                     k, cyc, out, e.kind, e.cyc, e.val);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_bit(input int hi, input int lo);
        @(negedge clk);
        sig = 1'b1;
        last_start = cyc;
        exp_q.push_back('{kind: 1'b0, val: (hi > SAMPLE), cyc: cyc + STB_LAT});
        repeat (hi) @(negedge clk);
        sig = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s pending=%0d next_cycle=%0d, required 0 pending", name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            vectors++;
            if ({out, strobe, stream_reset} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_idle cycle=%0d out/strobe/stream_reset=%b, required 000",
                         cyc, {out, strobe, stream_reset});
            end
        end
    endtask

    task automatic test_one_bits();
        drive_bit(62, 29);
        drive_bit(91, 29);
        check_drained("one_bits");
    endtask

    task automatic test_zero_bits();
        drive_bit(24, 67);
        drive_bit(52, 67);
        check_drained("zero_bits");
    endtask

    task automatic test_idle_low();
        drive_bit(62, 29);
        exp_q.push_back('{kind: 1'b1, val: 1'b0, cyc: last_start + IDLE_LAT});
        repeat (4900) @(negedge clk);
        drive_bit(62, 29);
        drive_bit(24, 67);
        check_drained("idle_low");
    endtask

    task automatic test_idle_high();
        @(negedge clk);
        sig = 1'b1;
        exp_q.push_back('{kind: 1'b0, val: 1'b1, cyc: cyc + STB_LAT});
        exp_q.push_back('{kind: 1'b1, val: 1'b0, cyc: cyc + IDLE_LAT});
        repeat (4900) @(negedge clk);
        sig = 1'b0;
        repeat (200) @(negedge clk);
        check_drained("idle_high");
    endtask

    task automatic test_reset_mid_bit();
        drive_bit(62, 29);
        @(negedge clk);
        sig = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({out, strobe, stream_reset} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset out/strobe/stream_reset=%b, required 000", {out, strobe, stream_reset});
        end
        @(negedge clk);
        sig = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_drained("reset_mid_bit");
        drive_bit(62, 29);
        check_drained("after_reset_bit");
    endtask

    task automatic test_back_to_back();
        drive_bit(58, 1);
        drive_bit(57, 2);
        drive_bit(91, 29);
        check_drained("back_to_back");
    endtask

    initial begin
        test_reset();
        test_one_bits();
        test_zero_bits();
        test_back_to_back();
        test_idle_low();
        test_idle_high();
        test_reset_mid_bit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
